// File: rtl/led_shift_ctrl.sv
// Game sequencer for the Stop-It 16-LED shifter.
// Drives the shifter's load/shift/blank controls, paces shifts from a slow
// tick, and grades the player's stop press against a target position.
// Optional build macro: LED_SHIFT_CTRL_SPEEDUP_EN. When it is defined, each
// hit shortens the next round's shift period by one tick, down to MIN_PERIOD.
// Handshake note: tick_i, start_i and stop_i are single-cycle strobes with no
// ready/back-pressure. load_o and shift_o are single-cycle strobes to the
// shifter, and the shifter is assumed to always accept them.
module led_shift_ctrl #(
    parameter int SHIFT_PERIOD = 8,
    parameter int BLINK_PERIOD = 4,
    parameter int MIN_PERIOD   = 2,
    parameter int NUM_LEDS     = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic [4:0] target_i,
    output logic       load_o,
    output logic       shift_o,
    output logic       off_o,
    output logic [4:0] score_o,
    output logic       hit_o,
    output logic       done_o,
    output logic [2:0] state_o
);

    localparam int PRW = (SHIFT_PERIOD > 2) ? $clog2(SHIFT_PERIOD) : 1;
    localparam int PW  = $clog2(SHIFT_PERIOD + 1);
    localparam int BW  = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        STOPPED = 3'd3,
        FULL    = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [PRW-1:0] presc_q, presc_d;
    logic [BW-1:0]  blink_q, blink_d;
    logic [4:0]     score_q, score_d;
    logic           hit_q, hit_d;
    logic           done_q, done_d;
    logic           off_q, off_d;
    logic [PW-1:0]  period_w;
    logic [PRW-1:0] period_m1;
    logic [4:0]     score_inc;
    logic           shift_due;
    logic           target_hit;

`ifdef LED_SHIFT_CTRL_SPEEDUP_EN
    logic [PW-1:0] period_q, period_d;
    assign period_w = period_q;
`else
    assign period_w = PW'(SHIFT_PERIOD);
`endif

    assign period_m1  = PRW'(period_w - PW'(1));
    assign score_inc  = score_q + 5'd1;
    // Stop outranks a shift that falls due on the same cycle.
    assign shift_due  = (state_q == RUN) && tick_i && !stop_i && (presc_q == period_m1);
    // A target of zero can never be a hit, even with an empty bar.
    assign target_hit = (target_i != 5'd0) && (score_q == target_i);

    // State and datapath registers, cleared asynchronously so a reset aborts a round at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            blink_q  <= '0;
            score_q  <= '0;
            hit_q    <= 1'b0;
            done_q   <= 1'b0;
            off_q    <= 1'b0;
`ifdef LED_SHIFT_CTRL_SPEEDUP_EN
            period_q <= PW'(SHIFT_PERIOD);
`endif
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            blink_q  <= blink_d;
            score_q  <= score_d;
            hit_q    <= hit_d;
            done_q   <= done_d;
            off_q    <= off_d;
`ifdef LED_SHIFT_CTRL_SPEEDUP_EN
            period_q <= period_d;
`endif
        end
    end

    // Next-state and datapath update for the round sequencer.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        blink_d  = blink_q;
        score_d  = score_q;
        hit_d    = hit_q;
        done_d   = done_q;
        off_d    = 1'b0;
`ifdef LED_SHIFT_CTRL_SPEEDUP_EN
        period_d = period_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) state_d = LOAD;
            end
            LOAD: begin
                presc_d = '0;
                score_d = '0;
                hit_d   = 1'b0;
                done_d  = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                if (stop_i) begin
                    hit_d   = target_hit;
                    done_d  = 1'b1;
                    blink_d = '0;
                    state_d = STOPPED;
                end else if (tick_i) begin
                    if (presc_q == period_m1) begin
                        presc_d = '0;
                        score_d = score_inc;
                        if (score_inc == 5'(NUM_LEDS)) begin
                            done_d  = 1'b1;
                            state_d = FULL;
                        end
                    end else begin
                        presc_d = presc_q + PRW'(1);
                    end
                end
            end
            STOPPED: begin
                off_d = off_q;
                if (start_i) begin
                    off_d   = 1'b0;
                    state_d = LOAD;
`ifdef LED_SHIFT_CTRL_SPEEDUP_EN
                    if (hit_q)
                        period_d = (period_q > PW'(MIN_PERIOD)) ? period_q - PW'(1) : PW'(MIN_PERIOD);
                    else
                        period_d = PW'(SHIFT_PERIOD);
`endif
                end else if (tick_i) begin
                    if (blink_q == BW'(BLINK_PERIOD - 1)) begin
                        blink_d = '0;
                        off_d   = ~off_q;
                    end else begin
                        blink_d = blink_q + BW'(1);
                    end
                end
            end
            FULL: begin
                if (start_i) begin
                    state_d = LOAD;
`ifdef LED_SHIFT_CTRL_SPEEDUP_EN
                    period_d = PW'(SHIFT_PERIOD);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_o  = (state_q == LOAD);
    assign shift_o = shift_due;
    assign off_o   = off_q;
    assign score_o = score_q;
    assign hit_o   = hit_q;
    assign done_o  = done_q;
    assign state_o = state_q;

endmodule

// File: doc/led_shift_ctrl.md
Name: led_shift_ctrl

Overview:
Game sequencer for the 16-LED shifter in the Stop-It game. It drives the shifter's load, shift and blank controls. Shifts are paced from a slow tick enable. The block captures the player's stop press and grades it against a target position. It sits between the debounced button/tick logic and the LED shifter, and reports score and hit status to the display logic.

Parameters:
SHIFT_PERIOD, 8, tick_i pulses between successive shift_o pulses (>=2)
BLINK_PERIOD, 4, tick_i pulses per blank/unblank half-cycle in STOPPED
MIN_PERIOD, 2, lower bound on shift period (SPEEDUP_EN only)
NUM_LEDS, 16, shifts until the bar is full

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
tick_i  in  1  single-cycle slow enable (e.g. 100 Hz strobe)
start_i  in  1  single-cycle start/restart pulse (debounced)
stop_i  in  1  single-cycle player stop pulse (debounced)
target_i  in  5  winning shift count, 1..NUM_LEDS
load_o  out  1  to shifter load_i; one-cycle pulse
shift_o  out  1  to shifter shift_i; one-cycle pulse
off_o  out  1  to shifter off_i; blanks LEDs
score_o  out  5  shifts performed in current round
hit_o  out  1  stop landed exactly on target
done_o  out  1  round over (stopped or full)
state_o  out  3  encoded FSM state for debug

Behaviour:
- Reset (async on rst_i=1): state IDLE. load_o=0, shift_o=0, off_o=0, score_o=0, hit_o=0, done_o=0. Prescaler and blink counters are 0. Effective period is SHIFT_PERIOD.
- Reset mid-round aborts immediately. No residual shift_o/load_o pulse is allowed after deassertion.
- State encoding: IDLE=0, LOAD=1, RUN=2, STOPPED=3, FULL=4.
- IDLE: all pulses low, off_o=0. start_i -> LOAD.
- LOAD: exactly one cycle.
  - load_o=1 (shifter loads the switches; the player clears with all-zero switches).
  - Clears score_o, hit_o, done_o and the prescaler.
  - Unconditionally -> RUN next cycle.
- RUN:
  - Each tick_i increments the prescaler.
  - On the tick where prescaler == period-1: shift_o=1 for that cycle, prescaler <= 0, score_o <= score_o+1.
  - shift_o is therefore aligned to the tick cycle. The first shift occurs on the period-th tick after LOAD.
  - If score_o becomes NUM_LEDS -> FULL (same edge as the final increment).
  - stop_i -> STOPPED: hit_o <= (score_o == target_i), done_o <= 1.
  - start_i ignored in RUN.
- STOPPED:
  - score_o/hit_o held.
  - off_o toggles every BLINK_PERIOD ticks, starting at 0 (blink counter cleared on entry).
  - start_i -> LOAD. stop_i ignored.
- FULL: done_o=1, hit_o=0, off_o=0 steady. start_i -> LOAD.
- Simultaneous events:
  - stop_i and a due shift in the same RUN cycle: stop wins. No shift_o, score unchanged.
  - stop_i on the cycle the 16th shift fires: stop wins, so a target of 15 is graded on score 15.
  - start_i and stop_i together outside RUN: start wins.
- Width rules:
  - score_o saturates at NUM_LEDS (cannot exceed it by construction).
  - target_i=0 or >NUM_LEDS never hits.
  - Prescaler width is $clog2(SHIFT_PERIOD).
- tick_i outside RUN/STOPPED is ignored. Only one shift_o is issued per tick.

Optional Feature:
LED_SHIFT_CTRL_SPEEDUP_EN
- Defined: a hit in STOPPED followed by start_i decrements the effective period by 1, floored at MIN_PERIOD.
  - A miss, or any FULL -> start, restores SHIFT_PERIOD.
  - Reset restores SHIFT_PERIOD.
- Undefined: period is constant SHIFT_PERIOD, and MIN_PERIOD is unused.

Test Plan:
1. Reset mid-RUN (score 5) -> all outputs 0, state_o=0 immediately (async). No shift_o after release.
2. start_i, tick every 10 clocks, SHIFT_PERIOD=8 -> load_o for exactly 1 cycle. First shift_o on the 8th tick; score_o=1,2,3 on the 8th, 16th and 24th ticks.
3. target_i=3, stop_i after third shift -> STOPPED, hit_o=1, done_o=1, score_o=3. off_o toggles every 4 ticks: 0,1,0,...
4. stop_i same cycle as the 4th shift-due tick -> no shift_o, score_o=3, STOPPED.
5. No stop -> 16 shift_o pulses, FULL, done_o=1, hit_o=0. Further ticks give no shift_o. start_i -> load_o then RUN, score_o=0.
6. SPEEDUP_EN defined: three consecutive hits -> periods 8,7,6,5. A miss then restart -> period 8. With MIN_PERIOD=6 the period floors at 6.
